// File: rtl/pipe_front_regs.sv
// pipe_front_regs
//
// Front-end pipeline registers of a 5-stage RISC core: the fetch PC, the
// IF/ID register and the control half of the ID/EX register, together with
// hazard statistics and two sticky health flags.
//
// Parameters
//   NOP_INSTR  instruction word placed in IF/ID on reset and on flush
//   CNT_W      width of each saturating statistics counter
//   MAX_STALL  consecutive stall cycles that trip the stall watchdog
//
// Ports
//   clk_i            rising-edge clock
//   rst_i            synchronous active-low reset
//   pc_next_i        next PC chosen by the fetch mux
//   instr_i          instruction memory word at pc_o
//   PCWrite_i        PC update enable (hazard unit)
//   Stall_i          IF/ID hold request (hazard unit)
//   NoOp_i           ID/EX bubble request (hazard unit)
//   Flush_i          branch-taken flush of IF/ID
//   ctrl_i           ID-stage control bundle
//                    {RegWrite, MemtoReg, MemRead, MemWrite, ALUOp[1:0], ALUSrc, Branch}
//   pc_o             current fetch PC
//   ifid_pc_o        IF/ID captured PC
//   ifid_instr_o     IF/ID captured instruction
//   ifid_valid_o     IF/ID holds a real instruction
//   idex_ctrl_o      ID/EX control bundle
//   idex_valid_o     ID/EX holds a real instruction
//   stall_cnt_o      cycles where IF/ID was held by a stall
//   bubble_cnt_o     bubbles inserted into ID/EX
//   flush_cnt_o      IF/ID flushes
//   proto_err_o      sticky: hazard inputs were inconsistent at least once
//   stall_timeout_o  sticky: a stall run reached MAX_STALL cycles
module pipe_front_regs #(
    parameter logic [31:0] NOP_INSTR = 32'h00000013,
    parameter int          CNT_W     = 16,
    parameter int          MAX_STALL = 8
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic [31:0]      pc_next_i,
    input  logic [31:0]      instr_i,
    input  logic             PCWrite_i,
    input  logic             Stall_i,
    input  logic             NoOp_i,
    input  logic             Flush_i,
    input  logic [7:0]       ctrl_i,
    output logic [31:0]      pc_o,
    output logic [31:0]      ifid_pc_o,
    output logic [31:0]      ifid_instr_o,
    output logic             ifid_valid_o,
    output logic [7:0]       idex_ctrl_o,
    output logic             idex_valid_o,
    output logic [CNT_W-1:0] stall_cnt_o,
    output logic [CNT_W-1:0] bubble_cnt_o,
    output logic [CNT_W-1:0] flush_cnt_o,
    output logic             proto_err_o,
    output logic             stall_timeout_o
);

    localparam int              RUN_W   = $clog2(MAX_STALL + 1);
    localparam logic [RUN_W-1:0] RUN_MAX = RUN_W'(MAX_STALL);

    logic [RUN_W-1:0] run_cnt;
    logic [RUN_W-1:0] run_next;
    logic             proto_bad;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + CNT_W'(1);
    endfunction

    // A stall must always come with a bubble and a frozen PC; any other
    // combination means the hazard unit and this block disagree.
    always_comb begin
        proto_bad = (Stall_i != NoOp_i) || (PCWrite_i == Stall_i);
    end

    // The run counter tracks raw Stall_i, so a flush that overrides the
    // stall in IF/ID still counts toward the watchdog.
    always_comb begin
        run_next = '0;
        if (Stall_i) begin
            run_next = (run_cnt == RUN_MAX) ? RUN_MAX : run_cnt + RUN_W'(1);
        end
    end

    // Fetch stage / IF-ID boundary
    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            pc_o         <= '0;
            ifid_pc_o    <= '0;
            ifid_instr_o <= NOP_INSTR;
            ifid_valid_o <= 1'b0;
        end else begin
            if (PCWrite_i) begin
                pc_o <= pc_next_i;
            end
            if (Flush_i) begin
                ifid_pc_o    <= '0;
                ifid_instr_o <= NOP_INSTR;
                ifid_valid_o <= 1'b0;
            end else if (!Stall_i) begin
                ifid_pc_o    <= pc_o;
                ifid_instr_o <= instr_i;
                ifid_valid_o <= 1'b1;
            end
        end
    end

    // ID-EX boundary
    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            idex_ctrl_o  <= '0;
            idex_valid_o <= 1'b0;
        end else if (NoOp_i) begin
            idex_ctrl_o  <= '0;
            idex_valid_o <= 1'b0;
        end else begin
            idex_ctrl_o  <= ctrl_i;
            idex_valid_o <= ifid_valid_o;
        end
    end

    // Statistics and health flags
    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            stall_cnt_o     <= '0;
            bubble_cnt_o    <= '0;
            flush_cnt_o     <= '0;
            run_cnt         <= '0;
            proto_err_o     <= 1'b0;
            stall_timeout_o <= 1'b0;
        end else begin
            if (Stall_i && !Flush_i) begin
                stall_cnt_o <= sat_inc(stall_cnt_o);
            end
            if (NoOp_i) begin
                bubble_cnt_o <= sat_inc(bubble_cnt_o);
            end
            if (Flush_i) begin
                flush_cnt_o <= sat_inc(flush_cnt_o);
            end
            run_cnt <= run_next;
            if (proto_bad) begin
                proto_err_o <= 1'b1;
            end
            if (run_next == RUN_MAX) begin
                stall_timeout_o <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_pipe_front_regs.sv
// tb_pipe_front_regs
//
// Bench for pipe_front_regs built with CNT_W=4 so counter saturation is
// reachable quickly. Directed scenarios are followed by a randomized run;
// every edge is compared against a behavioural model of the block.
module tb_pipe_front_regs;

    localparam logic [31:0] NOP = 32'h00000013;
    localparam int          CW  = 4;
    localparam int          MS  = 8;
    localparam int          CNT_MAX = (1 << CW) - 1;

    logic          clk = 1'b0;
    logic          rst_i;
    logic [31:0]   pc_next_i;
    logic [31:0]   instr_i;
    logic          PCWrite_i;
    logic          Stall_i;
    logic          NoOp_i;
    logic          Flush_i;
    logic [7:0]    ctrl_i;
    logic [31:0]   pc_o;
    logic [31:0]   ifid_pc_o;
    logic [31:0]   ifid_instr_o;
    logic          ifid_valid_o;
    logic [7:0]    idex_ctrl_o;
    logic          idex_valid_o;
    logic [CW-1:0] stall_cnt_o;
    logic [CW-1:0] bubble_cnt_o;
    logic [CW-1:0] flush_cnt_o;
    logic          proto_err_o;
    logic          stall_timeout_o;

    int tests = 0;
    int fails = 0;

    // Behavioural reference state
    logic [31:0] m_pc, m_ifid_pc, m_ifid_instr;
    logic        m_ifid_v, m_idex_v, m_perr, m_tout;
    logic [7:0]  m_ctrl;
    int          m_sc, m_bc, m_fc, m_run;

    pipe_front_regs #(
        .NOP_INSTR(NOP),
        .CNT_W    (CW),
        .MAX_STALL(MS)
    ) dut (
        .clk_i          (clk),
        .rst_i          (rst_i),
        .pc_next_i      (pc_next_i),
        .instr_i        (instr_i),
        .PCWrite_i      (PCWrite_i),
        .Stall_i        (Stall_i),
        .NoOp_i         (NoOp_i),
        .Flush_i        (Flush_i),
        .ctrl_i         (ctrl_i),
        .pc_o           (pc_o),
        .ifid_pc_o      (ifid_pc_o),
        .ifid_instr_o   (ifid_instr_o),
        .ifid_valid_o   (ifid_valid_o),
        .idex_ctrl_o    (idex_ctrl_o),
        .idex_valid_o   (idex_valid_o),
        .stall_cnt_o    (stall_cnt_o),
        .bubble_cnt_o   (bubble_cnt_o),
        .flush_cnt_o    (flush_cnt_o),
        .proto_err_o    (proto_err_o),
        .stall_timeout_o(stall_timeout_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp)
        else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic int inc_sat(input int v, input int lim);
        return (v >= lim) ? lim : v + 1;
    endfunction

    // Next-state of the reference, from the inputs currently applied.
    task automatic model_edge();
        logic [31:0] old_pc;
        logic        old_v;
        old_pc = m_pc;
        old_v  = m_ifid_v;
        if (!rst_i) begin
            m_pc = 0; m_ifid_pc = 0; m_ifid_instr = NOP; m_ifid_v = 0;
            m_ctrl = 0; m_idex_v = 0;
            m_sc = 0; m_bc = 0; m_fc = 0; m_run = 0; m_perr = 0; m_tout = 0;
        end else begin
            if (PCWrite_i) m_pc = pc_next_i;
            if (Flush_i) begin
                m_ifid_pc = 0; m_ifid_instr = NOP; m_ifid_v = 0;
            end else if (!Stall_i) begin
                m_ifid_pc = old_pc; m_ifid_instr = instr_i; m_ifid_v = 1;
            end
            if (NoOp_i) begin
                m_ctrl = 0; m_idex_v = 0;
            end else begin
                m_ctrl = ctrl_i; m_idex_v = old_v;
            end
            if (Stall_i && !Flush_i) m_sc = inc_sat(m_sc, CNT_MAX);
            if (NoOp_i)  m_bc = inc_sat(m_bc, CNT_MAX);
            if (Flush_i) m_fc = inc_sat(m_fc, CNT_MAX);
            if ((Stall_i != NoOp_i) || (PCWrite_i == Stall_i)) m_perr = 1;
            m_run = Stall_i ? inc_sat(m_run, MS) : 0;
            if (m_run == MS) m_tout = 1;
        end
    endtask

    task automatic check_all();
        chk("pc",          pc_o,                  m_pc);
        chk("ifid_pc",     ifid_pc_o,             m_ifid_pc);
        chk("ifid_instr",  ifid_instr_o,          m_ifid_instr);
        chk("ifid_valid",  32'(ifid_valid_o),     32'(m_ifid_v));
        chk("idex_ctrl",   32'(idex_ctrl_o),      32'(m_ctrl));
        chk("idex_valid",  32'(idex_valid_o),     32'(m_idex_v));
        chk("stall_cnt",   32'(stall_cnt_o),      32'(m_sc));
        chk("bubble_cnt",  32'(bubble_cnt_o),     32'(m_bc));
        chk("flush_cnt",   32'(flush_cnt_o),      32'(m_fc));
        chk("proto_err",   32'(proto_err_o),      32'(m_perr));
        chk("stall_tout",  32'(stall_timeout_o),  32'(m_tout));
    endtask

    task automatic step(input logic r, input logic pcw, input logic st, input logic no,
                        input logic fl, input logic [31:0] pn, input logic [31:0] ins,
                        input logic [7:0] c);
        rst_i = r; PCWrite_i = pcw; Stall_i = st; NoOp_i = no; Flush_i = fl;
        pc_next_i = pn; instr_i = ins; ctrl_i = c;
        model_edge();
        @(posedge clk);
        #1;
        check_all();
    endtask

    initial begin
        logic [31:0] sc_before;
        int          sel;

        // Reset
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'hDEAD0000, 32'h11111111, 8'hFF);
        step(1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 32'hDEAD0004, 32'h22222222, 8'hFF);
        chk("reset_instr", ifid_instr_o, NOP);

        // Straight-line fetch
        for (int i = 0; i < 4; i++) begin
            step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, m_pc + 32'd4, 32'h00A00093, 8'hA5);
        end
        chk("fetch_instr", ifid_instr_o, 32'h00A00093);

        // Load-use stall
        step(1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 32'h0000_0100, 32'h12345678, 8'h3C);
        chk("lu_stall_cnt", 32'(stall_cnt_o), 32'd1);
        chk("lu_bubble_cnt", 32'(bubble_cnt_o), 32'd1);
        chk("lu_proto", 32'(proto_err_o), 32'd0);

        // Flush during stall
        sc_before = 32'(stall_cnt_o);
        step(1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 32'h0000_0200, 32'h87654321, 8'h5A);
        chk("fl_instr", ifid_instr_o, 32'h00000013);
        chk("fl_stall_hold", 32'(stall_cnt_o), sc_before);

        // Protocol error, then legal traffic
        step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, m_pc + 32'd4, 32'h00B00113, 8'h81);
        step(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, m_pc + 32'd4, 32'h00B00113, 8'h81);
        for (int i = 0; i < 3; i++) begin
            step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, m_pc + 32'd4, 32'h00C00193, 8'h42);
        end
        chk("proto_sticky", 32'(proto_err_o), 32'd1);

        // Watchdog and counter saturation
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 8'h0);
        for (int i = 1; i <= 20; i++) begin
            step(1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 32'hFFFF_FFF0, 32'h0BAD0BAD, 8'hC3);
            if (i == 7) chk("wd_before", 32'(stall_timeout_o), 32'd0);
            if (i == 8) chk("wd_after8", 32'(stall_timeout_o), 32'd1);
        end
        chk("stall_sat", 32'(stall_cnt_o), 32'h0000000F);

        // Reset asserted mid-stall
        step(1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 32'h0000_4444, 32'h55555555, 8'hEE);
        chk("midrst_tout", 32'(stall_timeout_o), 32'd0);
        step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0000_0040, 32'h00A00093, 8'h11);

        // Randomized traffic
        for (int i = 0; i < 400; i++) begin
            logic r, pcw, st, no, fl;
            sel = int'($urandom_range(0, 9));
            r   = ($urandom_range(0, 49) != 0);
            fl  = ($urandom_range(0, 7) == 0);
            case (sel)
                0, 1, 2, 3, 4: begin pcw = 1'b1; st = 1'b0; no = 1'b0; end
                5, 6, 7:       begin pcw = 1'b0; st = 1'b1; no = 1'b1; end
                default: begin
                    pcw = 1'($urandom); st = 1'($urandom); no = 1'($urandom);
                end
            endcase
            step(r, pcw, st, no, fl, $urandom, $urandom, 8'($urandom));
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/pipe_front_regs.md
PIPE_FRONT_REGS -- requirements
Module: pipe_front_regs

Interface
REQ-001 SHALL have parameter NOP_INSTR, default 32'h00000013, the instruction word loaded into IF/ID on reset and flush.
REQ-002 SHALL have parameter CNT_W, default 16, the width of each statistics counter.
REQ-003 SHALL have parameter MAX_STALL, default 8, the consecutive stall cycles that trip the watchdog.
REQ-004 SHALL use one clock; reset is synchronous and active-low.
REQ-005 clk_i  in  1  rising-edge clock.
REQ-006 rst_i  in  1  synchronous active-low reset.
REQ-007 pc_next_i  in  32  next PC chosen by the fetch mux.
REQ-008 instr_i  in  32  instruction memory word at pc_o.
REQ-009 PCWrite_i  in  1  PC update enable from hazard detection.
REQ-010 Stall_i  in  1  IF/ID hold request from hazard detection.
REQ-011 NoOp_i  in  1  bubble request from hazard detection.
REQ-012 Flush_i  in  1  branch-taken flush of IF/ID.
REQ-013 ctrl_i  in  8  ID-stage control bundle {RegWrite, MemtoReg, MemRead, MemWrite, ALUOp[1:0], ALUSrc, Branch}.
REQ-014 pc_o  out  32  current fetch PC.
REQ-015 ifid_pc_o, ifid_instr_o  out  32 each  IF/ID register contents.
REQ-016 ifid_valid_o  out  1  IF/ID holds a real instruction.
REQ-017 idex_ctrl_o  out  8  ID/EX control bundle.
REQ-018 idex_valid_o  out  1  ID/EX holds a real instruction.
REQ-019 stall_cnt_o, bubble_cnt_o, flush_cnt_o  out  CNT_W each  event counters.
REQ-020 proto_err_o  out  1  sticky hazard-protocol violation.
REQ-021 stall_timeout_o  out  1  sticky watchdog flag.

Function
REQ-022 pc_o SHALL load pc_next_i on a clock edge when PCWrite_i=1 and SHALL hold otherwise.
REQ-023 IF/ID update SHALL follow the priority Flush_i > Stall_i > normal load.
REQ-024 Flush_i=1 SHALL load ifid_instr_o=NOP_INSTR, ifid_pc_o=0, and ifid_valid_o=0.
REQ-025 Stall_i=1 with Flush_i=0 SHALL hold all IF/ID fields unchanged.
REQ-026 A normal load SHALL capture pc_o, instr_i, and ifid_valid_o=1, with one-cycle latency.
REQ-027 NoOp_i=1 SHALL load idex_ctrl_o=8'h00 and idex_valid_o=0; otherwise ID/EX SHALL load ctrl_i and ifid_valid_o.
REQ-028 ID/EX SHALL NOT be affected by Flush_i.
REQ-029 Counter updates SHALL be evaluated independently each cycle:
- stall_cnt_o +1 when Stall_i=1 and Flush_i=0;
- bubble_cnt_o +1 when NoOp_i=1;
- flush_cnt_o +1 when Flush_i=1.
REQ-030 Each counter SHALL saturate at all-ones and SHALL NOT wrap.
REQ-031 proto_err_o SHALL set, and stay set until reset, in any cycle where Stall_i!=NoOp_i or PCWrite_i==Stall_i.
REQ-032 A run counter SHALL count consecutive cycles with Stall_i=1 and clear to 0 on any cycle with Stall_i=0.
REQ-033 stall_timeout_o SHALL set, sticky, on the edge where the run counter reaches MAX_STALL.
REQ-034 The run counter SHALL saturate at MAX_STALL.
REQ-035 When Flush_i and Stall_i are both 1 in the same cycle, flush SHALL win in IF/ID, the stall counter SHALL NOT increment, and the run counter SHALL still advance.

Reset
REQ-036 On any edge with rst_i=0 the block SHALL apply:
- pc_o=0, ifid_pc_o=0, ifid_instr_o=NOP_INSTR, ifid_valid_o=0;
- idex_ctrl_o=0, idex_valid_o=0;
- all counters, run counter, proto_err_o and stall_timeout_o = 0.
REQ-037 Reset asserted mid-stall SHALL override all other inputs on that edge.
REQ-038 The first edge with rst_i=1 SHALL perform normal operation.

Verification
REQ-039 Straight-line fetch: release reset; pc_next_i=pc_o+4, instr_i=0x00A00093, hazard inputs 0 -> pc_o=0,4,8 on successive edges; ifid_instr_o=0x00A00093, ifid_valid_o=1 one cycle after each load.
REQ-040 Load-use stall: one cycle of PCWrite_i=0, Stall_i=1, NoOp_i=1 -> pc_o and IF/ID hold; idex_ctrl_o=0, idex_valid_o=0; stall_cnt_o=1, bubble_cnt_o=1; proto_err_o=0.
REQ-041 Flush during stall: Flush_i=1, Stall_i=1, NoOp_i=1, PCWrite_i=0 -> ifid_instr_o=0x00000013, ifid_valid_o=0; flush_cnt_o+1; stall_cnt_o unchanged.
REQ-042 Protocol error: Stall_i=1, NoOp_i=0, PCWrite_i=0 for one cycle, then all inputs legal -> proto_err_o=1 and remains 1 until rst_i=0.
REQ-043 Watchdog and saturation: hold Stall_i=NoOp_i=1, PCWrite_i=0 for 8 cycles -> stall_timeout_o=1 after the 8th edge; with CNT_W=4, hold 20 cycles -> stall_cnt_o=4'hF.
REQ-044 Mid-operation reset: assert rst_i=0 for one edge during a stall -> every output equals its REQ-036 reset value on that edge.
